// File: rtl/bp_lite_to_burst_buffered_pkg.sv
// rtl/bp_lite_to_burst_buffered_pkg.sv - shared header type, FSM states and beat-count helper
package bp_lite_to_burst_buffered_pkg;

  localparam int paddr_width_gp    = 40;
  localparam int msg_type_width_gp = 4;
  localparam int size_width_gp     = 3;

  // Header layout shared by the lite input and the burst header channel.
  typedef struct packed {
    logic [paddr_width_gp-1:0]    addr;
    logic [size_width_gp-1:0]     size;
    logic [msg_type_width_gp-1:0] msg_type;
  } mem_header_t;

  localparam int header_width_gp = $bits(mem_header_t);

  typedef enum logic {
    PISO_IDLE  = 1'b0,
    PISO_BURST = 1'b1
  } piso_state_e;

  // Beats needed for a (1 << size)-byte message, never zero and never more than the payload holds.
  function automatic int beat_count(input logic [size_width_gp-1:0] size,
                                    input int out_bytes,
                                    input int burst_words);
    int n;
    n = (1 << size) / out_bytes;
    if (n < 1) n = 1;
    if (n > burst_words) n = burst_words;
    return n;
  endfunction

endpackage

// File: rtl/bp_lite_to_burst_buffered_fifo.sv
// rtl/bp_lite_to_burst_buffered_fifo.sv - small 1r1w header queue with registered full flag
module bp_lite_to_burst_buffered_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               full_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_width_lp = $clog2(els_p + 1);

  logic [width_p-1:0]      mem_r [els_p];
  logic [ptr_width_lp-1:0] wr_ptr_r, rd_ptr_r;
  logic [cnt_width_lp-1:0] count_r;
  logic                    enq, deq;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o = (count_r == cnt_width_lp'(els_p));
  assign v_o    = (count_r != '0);
  assign data_o = mem_r[rd_ptr_r];
  assign enq    = v_i & ~full_o;
  assign deq    = yumi_i & v_o;

  // Pointer and occupancy bookkeeping; reset empties the queue.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (deq) rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({enq, deq})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care until the count says otherwise.
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wr_ptr_r] <= data_i;
  end

endmodule

// File: rtl/bp_lite_to_burst_buffered_piso.sv
// rtl/bp_lite_to_burst_buffered_piso.sv - payload serializer with per-message beat count
module bp_lite_to_burst_buffered_piso
  import bp_lite_to_burst_buffered_pkg::*;
#(
  parameter int in_width_p  = 512,
  parameter int out_width_p = 64,
  parameter int cnt_width_p = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   load_i,
  input  logic [in_width_p-1:0]  data_i,
  input  logic [cnt_width_p-1:0] beats_i,
  output logic                   ready_o,
  output logic [out_width_p-1:0] data_o,
  output logic                   v_o,
  output logic                   last_o,
  input  logic                   yumi_i
);

  piso_state_e             state_r, state_n;
  logic [in_width_p-1:0]   payload_r;
  logic [cnt_width_p-1:0]  beats_r, idx_r;
  logic                    last_beat;

  // Current beat is always the low lane; the register shifts down after each handshake.
  assign data_o    = payload_r[out_width_p-1:0];
  assign last_beat = (idx_r == beats_r - cnt_width_p'(1));

  // State register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_r <= PISO_IDLE;
    else          state_r <= state_n;
  end

  // Next state and handshake outputs; ready also covers the final beat so a new load lands without a bubble.
  always_comb begin
    state_n = state_r;
    v_o     = 1'b0;
    last_o  = 1'b0;
    ready_o = 1'b0;
    case (state_r)
      PISO_IDLE: begin
        ready_o = 1'b1;
        if (load_i) state_n = PISO_BURST;
      end
      PISO_BURST: begin
        v_o     = 1'b1;
        last_o  = last_beat;
        ready_o = yumi_i & last_beat;
        if (yumi_i & last_beat) state_n = load_i ? PISO_BURST : PISO_IDLE;
      end
      default: state_n = PISO_IDLE;
    endcase
  end

  // Payload, beat count and beat index; a load always takes priority over advancing.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      payload_r <= '0;
      beats_r   <= '0;
      idx_r     <= '0;
    end else if (load_i) begin
      payload_r <= data_i;
      beats_r   <= beats_i;
      idx_r     <= '0;
    end else if (yumi_i) begin
      payload_r <= payload_r >> out_width_p;
      idx_r     <= idx_r + 1'b1;
    end
  end

endmodule

// File: rtl/bp_lite_to_burst_buffered.sv
// rtl/bp_lite_to_burst_buffered.sv - lite message to burst header/data stream converter
module bp_lite_to_burst_buffered
  import bp_lite_to_burst_buffered_pkg::*;
#(
  parameter int          in_data_width_p  = 512,
  parameter int          out_data_width_p = 64,
  parameter logic [15:0] payload_mask_p   = '0,
  parameter int          header_els_p     = 2,
  localparam int in_mem_msg_width_lp         = header_width_gp + in_data_width_p,
  localparam int out_mem_msg_header_width_lp = header_width_gp
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [in_mem_msg_width_lp-1:0]         mem_i,
  input  logic                                   mem_v_i,
  output logic                                   mem_ready_o,
  output logic [out_mem_msg_header_width_lp-1:0] mem_header_o,
  output logic                                   mem_header_v_o,
  input  logic                                   mem_header_ready_i,
  output logic [out_data_width_p-1:0]            mem_data_o,
  output logic                                   mem_data_v_o,
  output logic                                   mem_data_last_o,
  input  logic                                   mem_data_ready_i
);

  localparam int burst_words_lp = in_data_width_p / out_data_width_p;
  localparam int cnt_width_lp   = $clog2(burst_words_lp) + 1;
  localparam int out_bytes_lp   = out_data_width_p / 8;

  mem_header_t                 hdr_li;
  logic [in_data_width_p-1:0]  payload_li;
  logic                        has_data;
  logic [cnt_width_lp-1:0]     beats_li;
  logic                        accept;
  logic                        ready_en_r;
  logic                        hdr_full, hdr_yumi;
  logic                        piso_ready, piso_load, data_yumi;

  assign hdr_li     = mem_i[in_mem_msg_width_lp-1 -: header_width_gp];
  assign payload_li = mem_i[in_data_width_p-1:0];
  assign has_data   = payload_mask_p[hdr_li.msg_type];
  assign beats_li   = cnt_width_lp'(beat_count(hdr_li.size, out_bytes_lp, burst_words_lp));

  // Ready uses only registered state plus the outgoing data handshake, never mem_v_i.
  assign mem_ready_o = ready_en_r & ~hdr_full & piso_ready;
  assign accept      = mem_v_i & mem_ready_o;
  assign piso_load   = accept & has_data;
  assign hdr_yumi    = mem_header_v_o & mem_header_ready_i;
  assign data_yumi   = mem_data_v_o & mem_data_ready_i;

  // Holds ready low through reset and opens it on the first edge afterwards.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) ready_en_r <= 1'b0;
    else          ready_en_r <= 1'b1;
  end

  bp_lite_to_burst_buffered_fifo #(
    .width_p (header_width_gp),
    .els_p   (header_els_p)
  ) header_queue (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (hdr_li),
    .v_i     (accept),
    .full_o  (hdr_full),
    .data_o  (mem_header_o),
    .v_o     (mem_header_v_o),
    .yumi_i  (hdr_yumi)
  );

  bp_lite_to_burst_buffered_piso #(
    .in_width_p  (in_data_width_p),
    .out_width_p (out_data_width_p),
    .cnt_width_p (cnt_width_lp)
  ) data_piso (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (piso_load),
    .data_i  (payload_li),
    .beats_i (beats_li),
    .ready_o (piso_ready),
    .data_o  (mem_data_o),
    .v_o     (mem_data_v_o),
    .last_o  (mem_data_last_o),
    .yumi_i  (data_yumi)
  );

endmodule

// File: doc/bp_lite_to_burst_buffered.md
Name: bp_lite_to_burst_buffered

Overview:
Converts a BP Lite memory message (header plus full-width payload) into a BP Burst stream: a header channel plus a serialized data channel of out_data_width_p beats, with a last-beat flag. Successor to the single-entry lite-to-burst converter:
- configurable header queue depth;
- explicit acceptance gating on both header and data resources;
- correct beat counts for sizes narrower than one beat.

Sits between a lite master (cache/IO) and the burst-based memory/wormhole network.

Parameters:
bp_params_p, e_bp_default_cfg, processor config (paddr_width_p, lce_id_width_p, lce_assoc_p)
in_data_width_p, 512, lite payload width in bits; multiple of out_data_width_p
out_data_width_p, 64, burst beat width in bits; at least 8
payload_mask_p, 0, bit i set means msg_type i carries a data payload
header_els_p, 2, header queue depth; at least 1

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-low reset
mem_i  in  in_mem_msg_width_lp  lite message {header, data}
mem_v_i  in  1  lite valid
mem_ready_o  out  1  lite ready (ready-valid-and)
mem_header_o  out  out_mem_msg_header_width_lp  burst header
mem_header_v_o  out  1  header valid
mem_header_ready_i  in  1  header ready
mem_data_o  out  out_data_width_p  burst data beat
mem_data_v_o  out  1  data valid
mem_data_last_o  out  1  high on the final beat of a message
mem_data_ready_i  in  1  data ready

Behaviour:
- Reset (reset_i low, asynchronous):
  - header queue empty; data FSM in IDLE; beat counter 0.
  - mem_header_v_o=0, mem_data_v_o=0, mem_data_last_o=0.
  - mem_ready_o=0 while reset_i is low, and 1 from the first edge after release.
  - Reset mid-burst drops all queued headers and remaining beats; nothing is replayed.
- has_data = payload_mask_p[header.msg_type].
- Beat count:
  - beats = max(1, (1 << header.size) / out_data_bytes).
  - Saturates at burst_words = in_data_width_p / out_data_width_p.
  - Held in a counter of width clog2(burst_words)+1, so the full count is representable.
- mem_ready_o = queue not full AND (data FSM in IDLE, OR in BURST with the last beat handshaking this cycle).
  - The ready is independent of mem_v_i and of has_data, so the master never sees ready depend on its own valid.
- On accept (mem_v_i & mem_ready_o):
  - the header is enqueued;
  - if has_data, the payload and beats are loaded and the FSM moves to BURST;
  - if not, only the header is enqueued.
- Header queue: FIFO of header_els_p entries.
  - Dequeue on mem_header_v_o & mem_header_ready_i.
  - Enqueue and dequeue in the same cycle when full is permitted only if the dequeue is the reason space exists. Since ready is computed from the registered full flag, no enqueue occurs when full.
  - Header order equals lite acceptance order.
  - Headers are not required to precede data; the two channels are decoupled.
- Data FSM:
  - IDLE: mem_data_v_o=0. Load moves to BURST with idx=0.
  - BURST:
    - mem_data_v_o=1; mem_data_o = payload[idx*out_data_width_p +: out_data_width_p].
    - mem_data_last_o = (idx == beats-1).
    - On handshake: idx+1. If last, go to IDLE, or reload in the same cycle if a new payload message is accepted (back-to-back, zero bubble).
- Throughput: one beat per cycle under continuous ready. Header path latency is one cycle (registered queue output).
- Narrow sizes (1/2/4 B with 64-bit beats): exactly one beat, lane 0 of the payload; the master supplies replicated or aligned data.
- Stall: outputs remain stable while valid is high and ready is low (mem_data_o, mem_data_last_o, mem_header_o).

Decomposition:
- bp_me_pkg gains a function computing beats from size, data width and burst_words.
- Message structs come from the existing declare_bp_mem_if macros with in_mem and out_mem prefixes.
- One natural sub-module: bp_burst_piso_dynamic. It holds the payload register, beat counter, FSM and last flag, and exposes load/ready/v/yumi.
- The header queue reuses the existing small 1r1w FIFO.
- Assertions (translate_off): in width is a multiple of out width; header_els_p >= 1; no mem_v_i deassert while stalled is not required.

Test Plan:
- Write, size 64B, in=512, out=64, data = beat index pattern -> 1 header; 8 beats with values 0..7; last on beat 7 only; mem_ready_o low during beats 0..6.
- Read (msg_type not in payload_mask_p), size 64B -> 1 header, zero data beats; mem_ready_o stays high; 3 back-to-back reads with header_els_p=2 and header ready low -> 2 accepted, third stalls until one header dequeues.
- Write, size 8B, then size 2B -> one beat each carrying payload[63:0], last=1; size 128B saturates to 8 beats.
- Two 64B writes back-to-back with data ready always high -> 16 contiguous beats, no bubble; headers in acceptance order.
- Random mem_data_ready_i and mem_header_ready_i toggling -> data and header held stable while stalled; scoreboard matches payload slices.
- reset_i low at beat 3 of 8 -> all valids 0 immediately (asynchronous); after release, queue empty and a new write emits 8 fresh beats.
